// File: rtl/lcd_region_sched.sv
// Command/region sequencer and arbiter feeding one byte-wide SPI LCD stream (ST7789-class).
// Optional build macro LCD_SCHED_TESTPAT_EN replaces the pixel port with an internal colour bar.
module lcd_region_sched #(
    parameter int H_DISP = 135,
    parameter int V_DISP = 240,
    parameter int X_OFS  = 40,
    parameter int Y_OFS  = 53
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_byte,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_x0,
    input  logic [11:0] req_x1,
    input  logic [11:0] req_y0,
    input  logic [11:0] req_y1,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic [11:0] pix_hpos,
    output logic [11:0] pix_vpos,
    output logic        spi_valid,
    input  logic        spi_ready,
    output logic [7:0]  spi_byte,
    output logic        spi_dc,
    output logic        spi_last,
    output logic        busy,
    output logic        frame_done,
    output logic        req_err
);
    typedef enum logic [2:0] {IDLE, CMD, CASET, RASET, RAMWR, PIX_HI, PIX_LO, DONE} state_t;

    localparam logic [11:0] X_MAX   = 12'(H_DISP - 1);
    localparam logic [11:0] Y_MAX   = 12'(V_DISP - 1);
    localparam logic [15:0] X_OFS16 = 16'(X_OFS);
    localparam logic [15:0] Y_OFS16 = 16'(Y_OFS);

    function automatic logic [11:0] clamp_hi(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [15:0] add_ofs(input logic [11:0] v, input logic [15:0] ofs);
        return {4'd0, v} + ofs;
    endfunction

    function automatic logic [7:0] window_byte(input logic [2:0] i, input logic [7:0] opcode,
                                               input logic [15:0] lo, input logic [15:0] hi);
        logic [7:0] b;
        case (i)
            3'd0:    b = opcode;
            3'd1:    b = lo[15:8];
            3'd2:    b = lo[7:0];
            3'd3:    b = hi[15:8];
            default: b = hi[7:0];
        endcase
        return b;
    endfunction

`ifdef LCD_SCHED_TESTPAT_EN
    function automatic logic [15:0] bar_colour(input logic [11:0] row);
        logic [15:0] c;
        if (row < 12'(V_DISP / 3))          c = 16'hF800;
        else if (row < 12'(2 * V_DISP / 3)) c = 16'h07E0;
        else                                c = 16'h001F;
        return c;
    endfunction
`endif

    state_t      state, state_n;
    logic [2:0]  idx, idx_n;
    logic        last_grant, last_grant_n;    // 1 = region was granted last
    logic [11:0] x0_q, x1_q, y0_q, y1_q;
    logic [11:0] x0_n, x1_n, y0_n, y1_n;
    logic [15:0] pix_lat, pix_lat_n;
    logic [11:0] hpos_n, vpos_n;
    logic        spi_valid_n, spi_dc_n, spi_last_n;
    logic [7:0]  spi_byte_n;
    logic        cmd_ready_n, req_ready_n, frame_done_n, req_err_n;

    logic        slot_free;
    logic        pix_take;
    logic [15:0] pix_src;
    logic [11:0] x1_clamp, y1_clamp;
    logic        region_ok;
    logic        last_pixel;

    assign slot_free  = !spi_valid || spi_ready;
    assign x1_clamp   = clamp_hi(req_x1, X_MAX);
    assign y1_clamp   = clamp_hi(req_y1, Y_MAX);
    assign region_ok  = (req_x0 <= x1_clamp) && (req_y0 <= y1_clamp);
    assign last_pixel = (pix_hpos == x1_q) && (pix_vpos == y1_q);
    assign busy       = (state != IDLE);

`ifdef LCD_SCHED_TESTPAT_EN
    assign pix_ready = 1'b0;
    assign pix_take  = (state == PIX_HI) && slot_free;
    assign pix_src   = bar_colour(pix_vpos);
`else
    assign pix_ready = (state == PIX_HI) && slot_free && pix_valid;
    assign pix_take  = pix_ready;
    assign pix_src   = pix_data;
`endif

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        last_grant_n = last_grant;
        x0_n         = x0_q;
        x1_n         = x1_q;
        y0_n         = y0_q;
        y1_n         = y1_q;
        pix_lat_n    = pix_lat;
        hpos_n       = pix_hpos;
        vpos_n       = pix_vpos;
        spi_valid_n  = spi_valid && !spi_ready;
        spi_byte_n   = spi_byte;
        spi_dc_n     = spi_dc;
        spi_last_n   = spi_last;
        cmd_ready_n  = 1'b0;
        req_ready_n  = 1'b0;
        frame_done_n = 1'b0;
        req_err_n    = 1'b0;

        case (state)
            IDLE: begin
                // Granting only with an empty slot lets the granted state load its first byte at once.
                if (init_done && !spi_valid) begin
                    if (cmd_valid && (!req_valid || last_grant)) begin
                        cmd_ready_n  = 1'b1;
                        last_grant_n = 1'b0;
                        state_n      = CMD;
                    end else if (req_valid) begin
                        req_ready_n  = 1'b1;
                        last_grant_n = 1'b1;
                        idx_n        = 3'd0;
                        state_n      = CASET;
                    end
                end
            end
            CMD: begin
                spi_valid_n = 1'b1;
                spi_byte_n  = cmd_byte[7:0];
                spi_dc_n    = cmd_byte[8];
                spi_last_n  = 1'b1;
                state_n     = IDLE;
            end
            CASET: begin
                if (req_ready) begin
                    if (!region_ok) begin
                        req_err_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        x0_n        = req_x0;
                        x1_n        = x1_clamp;
                        y0_n        = req_y0;
                        y1_n        = y1_clamp;
                        spi_valid_n = 1'b1;
                        spi_byte_n  = 8'h2A;
                        spi_dc_n    = 1'b0;
                        spi_last_n  = 1'b0;
                        idx_n       = 3'd1;
                    end
                end else if (slot_free) begin
                    spi_valid_n = 1'b1;
                    spi_byte_n  = window_byte(idx, 8'h2A, add_ofs(x0_q, X_OFS16), add_ofs(x1_q, X_OFS16));
                    spi_dc_n    = 1'b1;
                    spi_last_n  = (idx == 3'd4);
                    if (idx == 3'd4) begin
                        idx_n   = 3'd0;
                        state_n = RASET;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            RASET: begin
                if (slot_free) begin
                    spi_valid_n = 1'b1;
                    spi_byte_n  = window_byte(idx, 8'h2B, add_ofs(y0_q, Y_OFS16), add_ofs(y1_q, Y_OFS16));
                    spi_dc_n    = (idx != 3'd0);
                    spi_last_n  = (idx == 3'd4);
                    if (idx == 3'd4) begin
                        idx_n   = 3'd0;
                        state_n = RAMWR;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            RAMWR: begin
                if (slot_free) begin
                    spi_valid_n = 1'b1;
                    spi_byte_n  = 8'h2C;
                    spi_dc_n    = 1'b0;
                    spi_last_n  = 1'b0;
                    hpos_n      = x0_q;
                    vpos_n      = y0_q;
                    state_n     = PIX_HI;
                end
            end
            PIX_HI: begin
                // Underflow simply holds here; no filler bytes are ever generated.
                if (pix_take) begin
                    pix_lat_n   = pix_src;
                    spi_valid_n = 1'b1;
                    spi_byte_n  = pix_src[15:8];
                    spi_dc_n    = 1'b1;
                    spi_last_n  = 1'b0;
                    state_n     = PIX_LO;
                end
            end
            PIX_LO: begin
                if (slot_free) begin
                    spi_valid_n = 1'b1;
                    spi_byte_n  = pix_lat[7:0];
                    spi_dc_n    = 1'b1;
                    spi_last_n  = last_pixel;
                    if (last_pixel) begin
                        state_n = DONE;
                    end else begin
                        state_n = PIX_HI;
                        if (pix_hpos == x1_q) begin
                            hpos_n = x0_q;
                            vpos_n = pix_vpos + 12'd1;
                        end else begin
                            hpos_n = pix_hpos + 12'd1;
                        end
                    end
                end
            end
            DONE: begin
                if (slot_free) begin
                    frame_done_n = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            last_grant <= 1'b1;
            x0_q       <= 12'd0;
            x1_q       <= 12'd0;
            y0_q       <= 12'd0;
            y1_q       <= 12'd0;
            pix_lat    <= 16'd0;
            pix_hpos   <= 12'd0;
            pix_vpos   <= 12'd0;
            spi_valid  <= 1'b0;
            spi_byte   <= 8'h00;
            spi_dc     <= 1'b1;
            spi_last   <= 1'b0;
            cmd_ready  <= 1'b0;
            req_ready  <= 1'b0;
            frame_done <= 1'b0;
            req_err    <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            last_grant <= last_grant_n;
            x0_q       <= x0_n;
            x1_q       <= x1_n;
            y0_q       <= y0_n;
            y1_q       <= y1_n;
            pix_lat    <= pix_lat_n;
            pix_hpos   <= hpos_n;
            pix_vpos   <= vpos_n;
            spi_valid  <= spi_valid_n;
            spi_byte   <= spi_byte_n;
            spi_dc     <= spi_dc_n;
            spi_last   <= spi_last_n;
            cmd_ready  <= cmd_ready_n;
            req_ready  <= req_ready_n;
            frame_done <= frame_done_n;
            req_err    <= req_err_n;
        end
    end
endmodule

// File: tb/tb_lcd_region_sched.sv
// Table-driven bench for lcd_region_sched: region vectors plus arbitration, stall and reset sequences.
module tb_lcd_region_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_byte = 9'd0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_x0 = 12'd0, req_x1 = 12'd0, req_y0 = 12'd0, req_y1 = 12'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [11:0] pix_hpos, pix_vpos;
    logic        spi_valid;
    logic        spi_ready = 1'b0;
    logic [7:0]  spi_byte;
    logic        spi_dc, spi_last, busy, frame_done, req_err;

    lcd_region_sched dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_hpos(pix_hpos), .pix_vpos(pix_vpos),
        .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_byte(spi_byte),
        .spi_dc(spi_dc), .spi_last(spi_last), .busy(busy),
        .frame_done(frame_done), .req_err(req_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x0, y0, x1, y1;
        int          npix;
        bit          err;
        int          mode;      // 0 steady, 1 spi_ready toggling, 2 pixel gap
        logic [79:0] hdr;       // CASET+RASET bytes, first byte in the top octet
    } vec_t;

    int passed = 0;
    int total  = 0;

    // Monitor state, written only by the negedge monitor.
    int          cyc = 0;
    logic [9:0]  blog[$];       // {dc, last, byte} per transferred byte
    logic [23:0] plog[$];       // {hpos, vpos} per consumed pixel
    int          grant_log[$];
    int          grant_cyc[$];
    int          fd_cnt = 0, fd_cyc = -1, err_cnt = 0, first_valid_cyc = -1;
    int          pcnt = 0, stab_viol = 0;
    bit          take_pend = 1'b0, prev_stall = 1'b0;
    logic [9:0]  prev_b = 10'd0;

    assign pix_data = {pcnt[7:0] ^ 8'hC3, pcnt[7:0]};

    always @(negedge clk) begin
        cyc++;
        if (take_pend) pcnt++;
        take_pend = 1'b0;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!spi_valid || {spi_dc, spi_last, spi_byte} != prev_b)) stab_viol++;
            prev_stall = spi_valid && !spi_ready;
            prev_b     = {spi_dc, spi_last, spi_byte};
            if (spi_valid && spi_ready) blog.push_back({spi_dc, spi_last, spi_byte});
            if (spi_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (req_err) err_cnt++;
            if (cmd_ready) begin grant_log.push_back(0); grant_cyc.push_back(cyc); end
            if (req_ready) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
            if (pix_valid && pix_ready) begin
                plog.push_back({pix_hpos, pix_vpos});
                take_pend = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] getb(input int i);
        return (i >= 0 && i < blog.size()) ? {22'd0, blog[i]} : 32'hDEAD;
    endfunction

    function automatic int getg(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic int getgc(input int i);
        return (i < grant_cyc.size()) ? grant_cyc[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_region(input vec_t v);
        int bb, pb, fb, eb, n, bad, gap_left;
        bit got, gap_done;
        logic [79:0] h;
        logic [7:0]  pk, hb;
        bb = blog.size(); pb = pcnt; fb = fd_cnt; eb = err_cnt;
        req_x0 = v.x0; req_y0 = v.y0; req_x1 = v.x1; req_y1 = v.y1;
        req_valid = 1'b1; spi_ready = 1'b1; pix_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        chk("req_grant", {31'd0, got}, 1);
        if (v.err) begin
            repeat (5) tick();
            chk("req_err_pulse", err_cnt - eb, 1);
            chk("err_no_bytes", blog.size() - bb, 0);
            return;
        end
        gap_left = 0; gap_done = 1'b0;
        for (int c = 0; c < 4 * v.npix + 200 && fd_cnt == fb; c++) begin
            if (v.mode == 1) spi_ready = ~spi_ready;
            if (v.mode == 2) begin
                if (!gap_done && pcnt - pb >= 2) begin
                    gap_done = 1'b1; gap_left = 7; pix_valid = 1'b0;
                end else if (gap_left > 0) begin
                    gap_left--;
                    if (gap_left == 0) pix_valid = 1'b1;
                end
            end
            @(negedge clk);
            if (v.mode == 2 && gap_left == 1) chk("gap_no_bytes", {31'd0, spi_valid}, 0);
            tick();
        end
        spi_ready = 1'b1;
        repeat (2) tick();
        chk("frame_done_once", fd_cnt - fb, 1);
        n = blog.size() - bb;
        chk("byte_count", n, 11 + 2 * v.npix);
        h = v.hdr;
        for (int k = 0; k < 10; k++) begin
            hb = h[79 - 8 * k -: 8];
            chk($sformatf("hdr_byte%0d", k), getb(bb + k),
                {22'd0, (k != 0 && k != 5), (k == 4 || k == 9), hb});
        end
        chk("ramwr_byte", getb(bb + 10), 32'h02C);
        bad = 0;
        for (int p = 0; p < v.npix; p++) begin
            pk = 8'(pb + p);
            if (getb(bb + 11 + 2 * p) !== {22'd0, 2'b10, pk ^ 8'hC3}) bad++;
            if (getb(bb + 12 + 2 * p) !== {22'd0, 1'b1, (p == v.npix - 1), pk}) bad++;
        end
        chk("pixel_bytes_bad", bad, 0);
    endtask

    vec_t tbl[6];
    vec_t sv;
    logic [23:0] exp_pos[4];
    int  phase, k, plb;
    bit  sc, sr, got;

    initial begin
        tbl[0] = '{12'd0,   12'd0,   12'd134, 12'd239, 32400, 1'b0, 0, 80'h2A002800AE2B00350124};
        tbl[1] = '{12'd100, 12'd0,   12'd200, 12'd0,   35,    1'b0, 0, 80'h2A008C00AE2B00350035};
        tbl[2] = '{12'd50,  12'd10,  12'd40,  12'd20,  0,     1'b1, 0, 80'h0};
        tbl[3] = '{12'd0,   12'd300, 12'd0,   12'd400, 0,     1'b1, 0, 80'h0};
        tbl[4] = '{12'd134, 12'd239, 12'd134, 12'd239, 1,     1'b0, 0, 80'h2A00AE00AE2B01240124};
        tbl[5] = '{12'd0,   12'd0,   12'd3,   12'd0,   4,     1'b0, 2, 80'h2A0028002B2B00350035};
        sv     = '{12'd10,  12'd5,   12'd11,  12'd6,   4,     1'b0, 1, 80'h2A003200332B003A003B};
        exp_pos = '{{12'd10, 12'd5}, {12'd11, 12'd5}, {12'd10, 12'd6}, {12'd11, 12'd6}};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_spi_valid", {31'd0, spi_valid}, 0);
        chk("rst_spi_out", {22'd0, spi_dc, spi_last, spi_byte}, 32'h200);
        chk("rst_flags", {26'd0, busy, cmd_ready, req_ready, pix_ready, frame_done, req_err}, 0);
        chk("rst_pos", {8'd0, pix_hpos, pix_vpos}, 0);

        // Arbitration: both valid after reset, command first, second command held off by the region.
        cmd_byte = 9'h021; cmd_valid = 1'b1;
        req_x0 = 12'd10; req_y0 = 12'd5; req_x1 = 12'd11; req_y1 = 12'd6; req_valid = 1'b1;
        spi_ready = 1'b1; pix_valid = 1'b1;
        repeat (4) tick();
        chk("no_grant_init_low", grant_log.size(), 0);
        init_done = 1'b1;
        phase = 0;
        for (int c = 0; c < 300 && phase < 3; c++) begin
            @(negedge clk);
            sc = cmd_ready; sr = req_ready;
            tick();
            if (phase == 0 && sc) begin
                cmd_valid = 1'b0; phase = 1;
            end else if (phase == 1 && sr) begin
                req_valid = 1'b0; cmd_byte = 9'h136; cmd_valid = 1'b1; phase = 2;
            end else if (phase == 2 && sc) begin
                cmd_valid = 1'b0; phase = 3;
            end
        end
        repeat (4) tick();
        chk("arb_complete", phase, 3);
        chk("arb_first_cmd", getg(0), 0);
        chk("arb_then_region", getg(1), 1);
        chk("arb_then_cmd", getg(2), 0);
        chk("grant_to_valid", first_valid_cyc - getgc(0), 1);
        chk("cmd_byte_out", getb(0), 32'h121);
        chk("region_first_byte", getb(1), 32'h02A);
        chk("cmd_after_frame", {31'd0, getgc(2) > fd_cyc}, 1);
        chk("arb_byte_total", blog.size(), 21);
        chk("second_cmd_out", getb(blog.size() - 1), 32'h336);

        for (int i = 0; i < 6; i++) run_region(tbl[i]);

        // Backpressure on the SPI side, with pixel positions tracked.
        plb = plog.size();
        run_region(sv);
        chk("pos_count", plog.size() - plb, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("pos%0d", i), (plb + i < plog.size()) ? {8'd0, plog[plb + i]} : 32'hDEAD,
                {8'd0, exp_pos[i]});
        chk("stable_during_stall", stab_viol, 0);

        // Reset in the middle of a pixel stream, then a fresh region.
        req_x0 = 12'd0; req_y0 = 12'd0; req_x1 = 12'd3; req_y1 = 12'd3;
        req_valid = 1'b1; spi_ready = 1'b1; pix_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 200 && k < 2; c++) begin
            @(negedge clk);
            if (pix_ready && pix_valid) k++;
            tick();
        end
        chk("rst_mid_reached", k, 2);
        chk("rst_mid_busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_spi_valid", {31'd0, spi_valid}, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        tick();
        rst = 1'b0;
        sv.mode = 0;
        run_region(sv);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lcd_region_sched.md
Name: lcd_region_sched

Overview:
- Sequencer and arbiter in front of the SPI LCD byte engine (ST7789-class panel, 135x240, RGB565).
- Shares one byte-wide output stream between two requesters:
  - a single-command port (e.g. invert, sleep, MADCTL);
  - a region-update port, expanded to CASET/RASET/RAMWR plus a streamed pixel payload.
- Runs only after the panel init sequence reports done.

Parameters:
- H_DISP, 135, visible columns.
- V_DISP, 240, visible rows.
- X_OFS, 40, panel column offset added to CASET values.
- Y_OFS, 53, panel row offset added to RASET values.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- init_done  in  1  panel init finished; no grants while low
- cmd_valid  in  1  single command request
- cmd_ready  out  1  command accepted this cycle
- cmd_byte  in  9  [8]=D/C (0 cmd, 1 data), [7:0] byte
- req_valid  in  1  region update request
- req_ready  out  1  region accepted this cycle
- req_x0, req_x1  in  12  inclusive column bounds
- req_y0, req_y1  in  12  inclusive row bounds
- pix_valid  in  1  pixel available
- pix_ready  out  1  pixel consumed this cycle
- pix_data  in  16  RGB565 pixel
- pix_hpos, pix_vpos  out  12  panel coordinate of the next pixel to be consumed
- spi_valid  out  1  byte valid to the SPI engine
- spi_ready  in  1  SPI engine takes the byte
- spi_byte  out  8  byte to shift, MSB first
- spi_dc  out  1  0 command, 1 data
- spi_last  out  1  deassert CS after this byte
- busy  out  1  not in IDLE
- frame_done  out  1  one-cycle pulse after the last pixel byte transfers
- req_err  out  1  one-cycle pulse when a region is rejected

Behaviour:
- Reset values:
  - spi_valid, cmd_ready, req_ready, pix_ready, busy, frame_done, req_err: 0.
  - spi_byte 8'h00, spi_dc 1, spi_last 0.
  - pix_hpos, pix_vpos 0; state IDLE; last_grant = region.
- Output handshake:
  - spi_* is a single registered slot; transfer occurs when spi_valid && spi_ready.
  - slot_free = !spi_valid || spi_ready.
  - A new byte loads only when slot_free; byte, dc and last stay stable while stalled.
- Arbitration (IDLE only, init_done=1):
  - Round-robin between cmd and req: the requester not granted last time wins when both are valid; a lone requester always wins.
  - Grant is signalled by a one-cycle cmd_ready/req_ready, and the request fields are latched.
  - No grants while a region is in progress; commands wait.
- Region validation at grant:
  - x1 clamped to H_DISP-1; y1 clamped to V_DISP-1.
  - If x0>x1 or y0>y1 after clamping: req_err pulses, no SPI bytes are issued, state returns to IDLE.
- States: IDLE, CMD, CASET, RASET, RAMWR, PIX_HI, PIX_LO, DONE. A 3-bit byte index is used inside CASET and RASET.
- CMD:
  - Emits cmd_byte[7:0] with dc=cmd_byte[8], last=1.
  - Returns to IDLE once the byte is loaded.
- CASET:
  - Emits 0x2A (dc=0), then (x0+X_OFS)[15:8], [7:0], (x1+X_OFS)[15:8], [7:0] (dc=1).
  - last=1 on the 5th byte.
  - Offset addition is 16-bit, zero-extended.
- RASET: same sequence with 0x2B, y0/y1 and Y_OFS.
- RAMWR:
  - Emits 0x2C (dc=0, last=0).
  - Sets pix_hpos=x0, pix_vpos=y0.
- PIX_HI:
  - pix_ready = slot_free && pix_valid (combinational AND gating into a registered slot).
  - On consumption, latch pix_data and emit [15:8] (dc=1, last=0).
  - If pix_valid is low, hold state; nothing is emitted. Underflow stalls and never pads.
- PIX_LO:
  - Emits [7:0]; last=1 only for the final pixel (hpos==x1 && vpos==y1).
  - Position advances: hpos wraps x1→x0 and increments vpos.
  - After the final pixel, go to DONE.
- DONE:
  - Waits for the last byte to transfer (spi_valid falls or spi_ready seen).
  - Pulses frame_done, returns to IDLE.
- Latency:
  - Grant to first spi_valid: 1 cycle.
  - Region of N pixels = 11 + 2N bytes.
- Reset mid-operation: next edge forces IDLE and spi_valid=0. The partial frame is abandoned; the SPI engine shares rst.
- init_done falling while busy: the current operation completes; new grants are blocked.

Optional Feature:
- Macro LCD_SCHED_TESTPAT_EN.
- When defined:
  - The pixel source is an internal colour bar; pix_ready is tied 0 and pix_data is ignored.
  - Bar selection by row: vpos < V_DISP/3 gives 16'hF800; vpos < 2*V_DISP/3 gives 16'h07E0; otherwise 16'h001F.
  - PIX_HI never stalls on underflow.
- When not defined: pixels come only from the pix_* handshake as above.

Test Plan:
- Full-screen region (0,0,134,239), spi_ready=1, pix_valid=1 → bytes 2A 00 28 00 AE, 2B 00 35 01 24, 2C, then 64800 pixel bytes (32400 pixels × 2); spi_last high on bytes 5, 10 and the final one; frame_done pulses once.
- cmd_valid and req_valid both high at idle with last_grant=region → cmd granted first (single byte, last=1), region granted next; a second cmd during the region waits until after frame_done.
- Region (10,5,11,6) with spi_ready toggling 1/0 → output bytes stable during stalls; pix_hpos/vpos sequence (10,5)(11,5)(10,6)(11,6).
- Region (100,0,200,0) → x1 clamped to 134, CASET bytes 00 8C 00 AE; region (50,10,40,20) → req_err pulse, no spi_valid.
- pix_valid deasserted for 7 cycles mid-region → no bytes emitted during the gap, no padding, byte count still 11+2N.
- rst asserted during PIX_LO → next cycle spi_valid=0, busy=0; a new request after release starts with 0x2A.
